pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It merges stall requests from ID (load-use), EX (multi-cycle unit) and MEM (data memory wait) into per-stage stall and bubble controls. It sequences exception entry and return: it flushes younger stages, drains MEM, then issues a one-cycle front-end redirect. It drives the `exn` input of the ID stage and holds the saved exception PC (epc).

---
 rtl/pipe_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard, stall and exception sequencing controller for the 5-stage pipeline
//
// Merges the stall requests from ID (load-use), EX (multi-cycle op) and MEM
// (data memory wait) into per-stage hold/bubble controls. Also sequences
// exception entry and return: younger stages are flushed, MEM is drained,
// and then the front end gets a one-cycle redirect.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_stall_req          load-use stall from ID
//   id_branch/_dest       taken branch resolved in ID and its target
//   ex_busy               multi-cycle EX op still running
//   mem_wait              data memory access not complete
//   exn_req, exn_pc       exception raised in MEM and its PC
//   eret_req              exception-return instruction in MEM
//   stall_if..stall_mem   per-stage register hold
//   bubble_ex/_mem        bubble insertion into EX / MEM
//   exn                   flush IF/ID/EX
//   redirect_valid/_pc    fetch restart request and address
//   epc                   saved exception PC
//   busy                  exception sequence in progress
//   stall_cycles, clr_cnt stall_if cycle counter and its synchronous clear

module pipe_ctrl #(
  parameter logic [31:0] EXN_VECTOR = 32'h0000_0100,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_stall_req,
  input  logic             id_branch,
  input  logic [31:0]      id_branch_dest,
  input  logic             ex_busy,
  input  logic             mem_wait,
  input  logic             exn_req,
  input  logic [31:0]      exn_pc,
  input  logic             eret_req,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             exn,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  input  logic             clr_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] cnt_q;
  logic             stalled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      epc_q    <= 32'h0;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  // All combinational outputs are gated by rst_n so the pipeline sees a
  // quiet controller for the whole reset window, not just after the edge.
  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    target_d       = target_q;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    bubble_ex      = 1'b0;
    bubble_mem     = 1'b0;
    exn            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    busy           = 1'b0;
    stalled        = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          // Oldest stage wins: a stalled MEM holds everything behind it,
          // a busy EX holds the front and lets MEM drain with a bubble.
          if (mem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
          end else if (ex_busy) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
          end else if (id_stall_req) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
          stalled = mem_wait | ex_busy | id_stall_req;

          if (exn_req) begin
            exn      = 1'b1;
            epc_d    = exn_pc;
            target_d = EXN_VECTOR;
            state_d  = mem_wait ? ST_DRAIN : ST_REDIRECT;
          end else if (eret_req) begin
            exn      = 1'b1;
            target_d = epc_q;
            state_d  = mem_wait ? ST_DRAIN : ST_REDIRECT;
          end else if (id_branch && !stalled) begin
            // The branch in ID is younger than anything trapping in MEM,
            // so it only steers fetch when nothing else is going on.
            redirect_valid = 1'b1;
            redirect_pc    = id_branch_dest;
          end
        end

        ST_DRAIN: begin
          busy      = 1'b1;
          exn       = 1'b1;
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = mem_wait;
          if (!mem_wait) begin
            state_d = ST_REDIRECT;
          end
        end

        ST_REDIRECT: begin
          busy           = 1'b1;
          exn            = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          state_d        = ST_RUN;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (stall_if) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign epc          = epc_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed and random stimulus
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0100;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_stall_req = 1'b0, id_branch = 1'b0, ex_busy = 1'b0, mem_wait = 1'b0;
  logic        exn_req = 1'b0, eret_req = 1'b0, clr_cnt = 1'b0;
  logic [31:0] id_branch_dest = '0, exn_pc = '0;
  logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem;
  logic        exn, redirect_valid, busy;
  logic [31:0] redirect_pc, epc;
  logic [CW-1:0] stall_cycles;

  pipe_ctrl #(.EXN_VECTOR(VEC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_stall_req(id_stall_req), .id_branch(id_branch), .id_branch_dest(id_branch_dest),
    .ex_busy(ex_busy), .mem_wait(mem_wait),
    .exn_req(exn_req), .exn_pc(exn_pc), .eret_req(eret_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .exn(exn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epc(epc), .busy(busy), .stall_cycles(stall_cycles), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sif, sid, sex, smem, bex, bmem, exn, rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic        busy;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle_no = 0;

  // Reference model: an exception is "waiting for memory" or "about to
  // redirect"; otherwise the pipeline runs.
  bit          m_wait_mem, m_redirect_next;
  logic [31:0] m_epc, m_target;
  int          m_cnt;

  task automatic cyc(input bit rn, mw, eb, isr, br, input logic [31:0] dest,
                     input bit xr, input logic [31:0] xpc, input bit er, cl);
    obs_t e;
    bit   any_stall;
    @(posedge clk);
    #1;
    rst_n = rn; mem_wait = mw; ex_busy = eb; id_stall_req = isr;
    id_branch = br; id_branch_dest = dest; exn_req = xr; exn_pc = xpc;
    eret_req = er; clr_cnt = cl;
    e = '0;
    if (!rn) begin
      m_wait_mem = 0; m_redirect_next = 0; m_epc = 0; m_target = 0; m_cnt = 0;
    end else begin
      e.epc = m_epc;
      e.cnt = CW'(m_cnt);
      if (m_redirect_next) begin
        e.rv = 1; e.rpc = m_target; e.exn = 1; e.busy = 1;
        m_redirect_next = 0;
      end else if (m_wait_mem) begin
        e.exn = 1; e.busy = 1; e.sif = 1; e.sid = 1; e.sex = 1; e.smem = mw;
        if (!mw) begin
          m_wait_mem = 0; m_redirect_next = 1;
        end
      end else begin
        any_stall = mw || eb || isr;
        e.sif  = any_stall;
        e.sid  = any_stall;
        e.sex  = mw || eb;
        e.smem = mw;
        e.bmem = !mw && eb;
        e.bex  = !mw && !eb && isr;
        if (xr || er) begin
          e.exn = 1;
          m_target = xr ? VEC : m_epc;
          if (xr) m_epc = xpc;
          if (mw) m_wait_mem = 1; else m_redirect_next = 1;
        end else if (br && !any_stall) begin
          e.rv = 1; e.rpc = dest;
        end
      end
      if (cl) m_cnt = 0;
      else if (e.sif) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, exn,
           redirect_valid, redirect_pc, epc, busy, stall_cycles};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cyc%0d outputs: got stl=%b%b%b%b bub=%b%b exn=%b rv=%b rpc=%h epc=%h busy=%b cnt=%0d, want stl=%b%b%b%b bub=%b%b exn=%b rv=%b rpc=%h epc=%h busy=%b cnt=%0d",
                 cycle_no, a.sif, a.sid, a.sex, a.smem, a.bex, a.bmem, a.exn, a.rv, a.rpc, a.epc, a.busy, a.cnt,
                 e.sif, e.sid, e.sex, e.smem, e.bex, e.bmem, e.exn, e.rv, e.rpc, e.epc, e.busy, e.cnt);
      end
      cycle_no++;
    end
  end

  initial begin
    // reset state, with noisy inputs that must not leak through
    cyc(0, 1, 1, 1, 1, 32'h1111, 1, 32'h2222, 1, 0);
    cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    // load-use
    cyc(1, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    // nested MEM + EX stall, then EX alone
    repeat (3) cyc(1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    cyc(1, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    // branch, then branch blocked by a stall
    cyc(1, 0, 0, 0, 1, 32'h2000, 0, 32'h0, 0, 0);
    cyc(1, 0, 0, 1, 1, 32'h2000, 0, 32'h0, 0, 0);
    // exception entry with a memory drain
    cyc(1, 1, 0, 0, 0, 32'h0, 1, 32'h1234, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 32'h0, 1, 32'h9999, 1, 0);
    idle(3);
    // simultaneous exn/eret, then eret alone
    cyc(1, 0, 0, 0, 1, 32'h3000, 1, 32'h40, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h5555, 1, 0);
    idle(2);
    // reset in the middle of a drain
    cyc(1, 1, 0, 0, 0, 32'h0, 1, 32'hABCD, 0, 0);
    cyc(1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(2);
    // counter wrap and clear priority
    repeat (16) cyc(1, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    cyc(1, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 1);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(99) != 0,
          $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
          $urandom_range(4) < 2, $urandom(),
          $urandom_range(15) == 0, $urandom(), $urandom_range(15) == 0,
          $urandom_range(29) == 0);
    end
    repeat (2) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
